// File: rtl/priority_decoder_pulse.sv
// Sequential 3-to-8 decoder: each accepted index drives one bit of D for PULSE_LEN cycles,
// followed by a single all-zero gap cycle; a one-entry holding register queues the next index.
module priority_decoder_pulse #(
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Y,
  input  logic       Valid,
  output logic       Ready,
  output logic [7:0] D,
  output logic       Busy,
  output logic       Overrun
);

  localparam logic [7:0] CntReload = 8'(PULSE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] act_q, act_d;
  logic [2:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] d_q, d_d;
  logic       overrun_q;
  logic       xfer;

  assign Ready = ~hold_full_q;
  assign xfer  = Valid & Ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      act_q       <= 3'd0;
      hold_q      <= 3'd0;
      hold_full_q <= 1'b0;
      d_q         <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      d_q         <= d_d;
      overrun_q   <= overrun_q | (Valid & ~Ready);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          act_d   = Y;
          cnt_d   = CntReload;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = StGap;
        if (xfer) begin
          hold_d      = Y;
          hold_full_d = 1'b1;
        end
      end
      StGap: begin
        // The held index takes priority; a direct transfer can only occur with hold empty.
        if (hold_full_q) begin
          act_d       = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = CntReload;
          state_d     = StDrive;
        end else if (xfer) begin
          act_d   = Y;
          cnt_d   = CntReload;
          state_d = StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // D lags the state register by one cycle, so it never depends on Y combinationally.
  always_comb begin
    d_d = 8'd0;
    if (state_q == StDrive) d_d = 8'd1 << act_q;
  end

  assign D       = d_q;
  assign Busy    = (state_q != StIdle);
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_priority_decoder_pulse.sv
// Directed bench for priority_decoder_pulse: PULSE_LEN=4 instance for pulse/hold/overrun/bypass
// and reset behaviour, PULSE_LEN=1 instance for the full index sweep.
module tb_priority_decoder_pulse;

  logic       clk = 1'b0;
  logic       rst4, v4, rst1, v1;
  logic [2:0] y4, y1;
  logic [7:0] d4, d1;
  logic       rdy4, busy4, ovr4, rdy1, busy1, ovr1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  priority_decoder_pulse #(.PULSE_LEN(4)) u_dut4 (
    .clk(clk), .reset(rst4), .Y(y4), .Valid(v4),
    .Ready(rdy4), .D(d4), .Busy(busy4), .Overrun(ovr4)
  );

  priority_decoder_pulse #(.PULSE_LEN(1)) u_dut1 (
    .clk(clk), .reset(rst1), .Y(y1), .Valid(v1),
    .Ready(rdy1), .D(d1), .Busy(busy1), .Overrun(ovr1)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_held [9];
    logic [7:0] exp_ovr  [9];
    exp_held = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    exp_ovr  = '{8'h02, 8'h02, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};

    // Reset with a transfer presented: it must be discarded.
    rst4 = 1'b1; v4 = 1'b1; y4 = 3'd5;
    rst1 = 1'b1; v1 = 1'b1; y1 = 3'd5;
    tick(); tick();
    chk("rst_d4", d4, 8'h00);      chk("rst_busy4", {7'd0, busy4}, 8'h00);
    chk("rst_rdy4", {7'd0, rdy4}, 8'h01); chk("rst_ovr4", {7'd0, ovr4}, 8'h00);
    chk("rst_d1", d1, 8'h00);      chk("rst_busy1", {7'd0, busy1}, 8'h00);
    rst4 = 1'b0; v4 = 1'b0; rst1 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_d4", d4, 8'h00);
      chk("post_rst_busy4", {7'd0, busy4}, 8'h00);
    end

    // Single pulse Y=3.
    v4 = 1'b1; y4 = 3'd3;
    tick();
    v4 = 1'b0; y4 = 3'bxxx;
    chk("sp_busy_rise", {7'd0, busy4}, 8'h01);
    chk("sp_latency_d", d4, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sp_d", d4, 8'h08);
      chk("sp_busy", {7'd0, busy4}, 8'h01);
    end
    tick();
    chk("sp_gap_d", d4, 8'h00);
    chk("sp_busy_fall", {7'd0, busy4}, 8'h00);

    // Held next index: Y=7 then Y=0 during DRIVE.
    v4 = 1'b1; y4 = 3'd7;
    tick();
    y4 = 3'd0;
    chk("held_rdy_pre", {7'd0, rdy4}, 8'h01);
    tick();
    v4 = 1'b0;
    chk("held_rdy_full", {7'd0, rdy4}, 8'h00);
    chk("held_d_first", d4, 8'h80);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("held_d", d4, exp_held[i]);
      chk("held_rdy", {7'd0, rdy4}, (i < 3) ? 8'h00 : 8'h01);
    end
    chk("held_ovr", {7'd0, ovr4}, 8'h00);
    chk("held_busy_end", {7'd0, busy4}, 8'h00);

    // Overrun: Y=1 active, Y=4 held, Y=2 dropped.
    v4 = 1'b1; y4 = 3'd1;
    tick();
    y4 = 3'd4;
    tick();
    y4 = 3'd2;
    tick();
    v4 = 1'b0;
    chk("ovr_set", {7'd0, ovr4}, 8'h01);
    chk("ovr_rdy", {7'd0, rdy4}, 8'h00);
    chk("ovr_d_first", d4, 8'h02);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("ovr_d", d4, exp_ovr[i]);
    end
    chk("ovr_sticky", {7'd0, ovr4}, 8'h01);

    // Bypass: transfer Y=6 exactly in the GAP cycle with hold empty.
    v4 = 1'b1; y4 = 3'd1;
    tick();
    v4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("byp_d_first", d4, 8'h02);
    end
    v4 = 1'b1; y4 = 3'd6;
    tick();
    v4 = 1'b0;
    chk("byp_gap_d", d4, 8'h00);
    chk("byp_busy", {7'd0, busy4}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("byp_d_second", d4, 8'h40);
    end
    tick();
    chk("byp_end_d", d4, 8'h00);

    // Mid-pulse reset with an index held: pulse truncated, held index discarded.
    v4 = 1'b1; y4 = 3'd2;
    tick();
    y4 = 3'd5;
    tick();
    v4 = 1'b0;
    tick();
    chk("mrst_pre_d", d4, 8'h04);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    chk("mrst_d", d4, 8'h00);
    chk("mrst_busy", {7'd0, busy4}, 8'h00);
    chk("mrst_rdy", {7'd0, rdy4}, 8'h01);
    chk("mrst_ovr", {7'd0, ovr4}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_quiet_d", d4, 8'h00);
    end

    // PULSE_LEN=1 sweep, one transfer every other cycle (bypass in GAP).
    for (int k = 0; k < 8; k++) begin
      v1 = 1'b1; y1 = 3'(k);
      tick();
      v1 = 1'b0;
      chk("sweep_gap_d", d1, 8'h00);
      tick();
      chk("sweep_d", d1, 8'h01 << k);
    end
    tick();
    chk("sweep_end_d", d1, 8'h00);
    chk("sweep_busy", {7'd0, busy1}, 8'h00);
    chk("sweep_ovr", {7'd0, ovr1}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
